// File: rtl/aud_pkg.sv
// Shared types and constants for the audio recorder: the FSM state encoding and the
// SRAM/sample geometry.
package aud_pkg;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned SAMPLE_W = 16;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    STORE,
    PAUSED,
    DONE
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s inside {WAIT_FRAME, CAPTURE, STORE});
  endfunction

endpackage

// File: rtl/aud_if.sv
// Recorder bus: control pulses and codec pins in, SRAM write port and status out.
interface aud_if;
  import aud_pkg::*;

  logic                i_start;
  logic                i_pause;
  logic                i_stop;
  logic                i_bclk;
  logic                i_lrc;
  logic                i_data;
  logic [ADDR_W-1:0]   o_address;
  logic [SAMPLE_W-1:0] o_data;
  logic                o_wr;
  logic                o_busy;
  logic                o_full;
  logic [ADDR_W-1:0]   o_last_addr;

  modport master (
    output i_start, i_pause, i_stop, i_bclk, i_lrc, i_data,
    input  o_address, o_data, o_wr, o_busy, o_full, o_last_addr
  );

  modport slave (
    input  i_start, i_pause, i_stop, i_bclk, i_lrc, i_data,
    output o_address, o_data, o_wr, o_busy, o_full, o_last_addr
  );

endinterface

// File: rtl/aud_sync.sv
// Two-flop synchronizer for a vector of asynchronous inputs, with one-cycle
// rise/fall pulses derived from the synchronized value.
module aud_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures 16-bit left samples from the codec ADC and
// writes them to consecutive SRAM words until stopped or memory is exhausted.
module aud_recorder
  import aud_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  aud_if.slave bus
);

  logic [2:0] raw;
  logic [2:0] sync;
  logic [2:0] rise;
  logic [2:0] fall;

  assign raw = {bus.i_bclk, bus.i_lrc, bus.i_data};

  aud_sync #(.W(3)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (raw),
    .q     (sync),
    .rise  (rise),
    .fall  (fall)
  );

  logic bclk_rise;
  logic lrc_fall;
  logic sdata;
  logic unused_edges;

  assign bclk_rise    = rise[2];
  assign lrc_fall     = fall[1];
  assign sdata        = sync[0];
  assign unused_edges = ^{sync[2:1], rise[1:0], fall[2], fall[0]};

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   last_q;
  logic [SAMPLE_W-1:0] data_q;
  logic [SAMPLE_W-2:0] shift_q;
  logic [3:0]          cnt_q;
  logic                skip_q;
  logic                wr_q;
  logic                full_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      wr_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_start && !bus.i_pause && !bus.i_stop) begin
            addr_q  <= '0;
            full_q  <= 1'b0;
            state_q <= WAIT_FRAME;
          end
        end

        WAIT_FRAME: begin
          if (bus.i_stop) begin
            state_q <= IDLE;
          end else if (bus.i_pause) begin
            state_q <= PAUSED;
          end else if (lrc_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
            skip_q  <= 1'b1;
            state_q <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (bus.i_stop || bus.i_pause) begin
            shift_q <= '0;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
            state_q <= bus.i_stop ? IDLE : PAUSED;
          end else if (bclk_rise) begin
            if (skip_q) begin
              skip_q <= 1'b0;
            end else begin
              shift_q <= {shift_q[SAMPLE_W-3:0], sdata};
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd15) begin
                data_q  <= {shift_q, sdata};
                wr_q    <= 1'b1;
                state_q <= STORE;
              end
            end
          end
        end

        // The write is already on the bus this cycle; stop/pause only pick the successor.
        STORE: begin
          last_q <= addr_q;
          cnt_q  <= '0;
          if (addr_q == MAX_ADDR) begin
            full_q  <= 1'b1;
            state_q <= bus.i_stop ? IDLE : DONE;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            if (bus.i_stop)       state_q <= IDLE;
            else if (bus.i_pause) state_q <= PAUSED;
            else                  state_q <= WAIT_FRAME;
          end
        end

        PAUSED: begin
          if (bus.i_stop) begin
            state_q <= IDLE;
          end else if (bus.i_start && !bus.i_pause) begin
            state_q <= WAIT_FRAME;
          end
        end

        DONE: begin
          if (bus.i_stop) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_address   = addr_q;
  assign bus.o_data      = data_q;
  assign bus.o_wr        = wr_q;
  assign bus.o_busy      = is_busy(state_q);
  assign bus.o_full      = full_q;
  assign bus.o_last_addr = last_q;

endmodule
